gfx_sdram_responder: RTL and testbench
======================================

Name: gfx_sdram_responder

Overview:
Responder end of the 32-bit graphics read channel (sdr_addr/sdr_req/sdr_data/sdr_rdy) driven by the GFX arbiter. It accepts a one-cycle request pulse with a 25-bit byte address and performs a two-beat 16-bit read on the SDRAM controller port. It assembles the two halfwords into one 32-bit word and returns it with a one-cycle sdr_rdy pulse. It sits between the GFX arbiter and the shared SDRAM controller, on a single clock.

Parameters:
TIMEOUT_CYCLES, 255, cycles from mem_req assertion to the second beat before the transaction is aborted; 0 disables the timeout.
ERR_DATA, 32'hFFFF_FFFF, data returned on timeout.

Ports:
clk  in  1  system clock; all logic is on its rising edge
reset  in  1  asynchronous, active-high reset
sdr_addr  in  25  byte address, sampled when sdr_req=1; bits [1:0] ignored
sdr_req  in  1  one-cycle request pulse
sdr_data  out  32  read data, valid while sdr_rdy=1 and held after
sdr_rdy  out  1  one-cycle completion pulse
mem_addr  out  25  halfword-pair base address to the controller, with [1:0]=0
mem_req  out  1  level request, held until mem_ack
mem_ack  in  1  controller has accepted the command (one-cycle pulse)
mem_dv  in  1  data beat valid; exactly two beats per command, low halfword first
mem_q  in  16  beat data
busy  out  1  a transaction is in flight or pending
overflow  out  1  sticky; a request was dropped; cleared only by reset
timeout_cnt  out  8  saturating count of timed-out transactions

Behaviour:
- Reset values (asynchronous): sdr_data=0, sdr_rdy=0, mem_req=0, mem_addr=0, busy=0, overflow=0, timeout_cnt=0; state=IDLE; pending register empty.
- A reset during any state abandons the transaction. mem_req drops immediately and no sdr_rdy is issued. Late mem_dv beats after reset are ignored in IDLE.
- States:
  - IDLE: if sdr_req, or the pending register is valid (pending takes priority), load mem_addr={addr[24:2],2'b00}, set mem_req=1 and go to CMD.
  - CMD: hold mem_req. On mem_ack, clear mem_req and go to BEAT0.
  - BEAT0: on mem_dv, latch sdr_data[15:0]=mem_q and go to BEAT1.
  - BEAT1: on mem_dv, latch sdr_data[31:16]=mem_q, pulse sdr_rdy next cycle and go to IDLE.
- mem_dv in the same cycle as mem_ack is accepted as beat 0.
- Latency: if mem_ack is in cycle N and the beats are in N+1 and N+2, sdr_rdy is in N+3. Minimum request-to-rdy latency with zero-wait ack is 4 cycles.
- Back-to-back: a new command may be issued in the same cycle as sdr_rdy; the pending request is taken in that cycle.
- Pending register:
  - It is one deep.
  - An sdr_req while not IDLE stores its address there.
  - An sdr_req while pending is already valid is dropped and sets overflow.
  - An sdr_req in the cycle the FSM returns to IDLE with pending empty is issued directly.
- busy = (state != IDLE) | pending_valid.
- Timeout:
  - The counter starts when leaving IDLE and is compared against TIMEOUT_CYCLES.
  - On expiry in any non-IDLE state: mem_req=0, sdr_data=ERR_DATA, sdr_rdy pulses, timeout_cnt increments (saturating at 255), state returns to IDLE.
  - Stray mem_dv beats received in IDLE are discarded.
- sdr_rdy is never high for two consecutive cycles. Exactly one sdr_rdy is issued per accepted (non-dropped) request.

Optional Feature:
Macro GFX_SDRAM_LINE_CACHE_EN.
- With the macro: a one-entry 32-bit cache (tag = addr[24:2] plus a valid bit) is filled on every successful read.
  - A request whose tag matches while IDLE returns the cached word with sdr_rdy on the next cycle, with no mem_req.
  - Timed-out reads invalidate the entry. Reset clears the valid bit.
- Without the macro: every request goes to the controller, and no tag or valid storage exists.

Decomposition:
- Package gfx_sdram_pkg: the state enum typedef (IDLE, CMD, BEAT0, BEAT1), the 25-bit address typedef, ERR_DATA default constant, and the timeout counter width.
- One sub-module, gfx_sdram_req_fifo1: the one-deep pending register with overflow flag. Everything else is inline.

Test Plan:
- Single read: sdr_req with addr 0x0100006; ack with 1-cycle latency; beats 0x1234 then 0xABCD -> mem_addr=0x0100004; sdr_data=0xABCD1234 with one sdr_rdy pulse, 4 cycles after the request.
- Ack and first beat in the same cycle, second beat 3 cycles later -> data assembled correctly; sdr_rdy the cycle after beat 1.
- Requests A, then B during A, then C during A -> A and B complete in order (B's mem_req in A's sdr_rdy cycle); C is dropped; overflow=1; two sdr_rdy pulses in total.
- Controller never acks with TIMEOUT_CYCLES=10 -> sdr_rdy 10 cycles after issue with data 0xFFFFFFFF; timeout_cnt=1; a late mem_dv is ignored; the next request succeeds.
- Reset asserted in BEAT1 -> mem_req, sdr_rdy and busy go to 0 immediately; no sdr_rdy after release; a fresh request completes normally.
- With GFX_SDRAM_LINE_CACHE_EN, read 0x200 twice -> the second read produces no mem_req and sdr_rdy one cycle later with identical data. After a timeout on 0x200, the next read of 0x200 goes to the controller.

Source files
------------

// File: rtl/gfx_sdram_pkg.sv
// gfx_sdram_pkg: shared types and constants for the GFX
// SDRAM read responder.
package gfx_sdram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    BEAT0,
    BEAT1
  } state_t;

  typedef logic [24:0] addr_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hFFFF_FFFF;
  localparam int          TO_W         = 8;
  localparam addr_t       ADDR_MASK    = 25'h1FF_FFFC;

endpackage

// File: rtl/gfx_sdram_req_fifo1.sv
// gfx_sdram_req_fifo1: one-deep pending request slot
// with a sticky overflow flag.
module gfx_sdram_req_fifo1
  import gfx_sdram_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  logic  pop,
  input  addr_t din,
  output logic  valid,
  output addr_t dout,
  output logic  overflow
);

  // a push into a full slot that is not draining is lost
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid    <= 1'b0;
      dout     <= '0;
      overflow <= 1'b0;
    end else if (push && valid && !pop) begin
      overflow <= 1'b1;
    end else if (push) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/gfx_sdram_responder.sv
// gfx_sdram_responder: 32-bit read responder doing two 16-bit
// beats on the SDRAM port. Optional GFX_SDRAM_LINE_CACHE_EN.
module gfx_sdram_responder
  import gfx_sdram_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [24:0] sdr_addr,
  input  logic        sdr_req,
  output logic [31:0] sdr_data,
  output logic        sdr_rdy,
  output logic [24:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic        mem_dv,
  input  logic [15:0] mem_q,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  timeout_cnt
);

  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT_CYCLES - 1);

  state_t            state, state_n;
  logic [TO_W-1:0]   to_cnt, to_cnt_n;
  logic [7:0]        tcnt_n;
  logic [24:0]       mem_addr_n;
  logic              mem_req_n;
  logic [31:0]       sdr_data_n;
  logic              sdr_rdy_n;
  logic              pend_valid;
  addr_t             pend_addr;
  addr_t             req_base;
  logic              req_v;
  logic              push, pop;
  logic              expire;
  logic              hit;
  logic [31:0]       hit_data;

  assign req_v    = sdr_req | pend_valid;
  assign req_base = (pend_valid ? pend_addr : sdr_addr)
                  & ADDR_MASK;
  assign push     = sdr_req & ~((state == IDLE) & ~pend_valid);
  assign expire   = (TIMEOUT_CYCLES != 0) && (state != IDLE)
                  && (to_cnt == TO_LAST);
  assign busy     = (state != IDLE) | pend_valid;

  gfx_sdram_req_fifo1 u_pend (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .din      (sdr_addr),
    .valid    (pend_valid),
    .dout     (pend_addr),
    .overflow (overflow)
  );

`ifdef GFX_SDRAM_LINE_CACHE_EN
  logic        c_valid;
  logic [22:0] c_tag;
  logic [31:0] c_data;
  logic        fill;

  assign fill     = (state == BEAT1) && mem_dv && !expire;
  assign hit      = c_valid && (c_tag == req_base[24:2])
                  && (state == IDLE) && req_v && !sdr_rdy;
  assign hit_data = c_data;

  // line cache: fill on good reads, drop on timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_valid <= 1'b0;
      c_tag   <= '0;
      c_data  <= '0;
    end else if (expire) begin
      c_valid <= 1'b0;
    end else if (fill) begin
      c_valid <= 1'b1;
      c_tag   <= mem_addr[24:2];
      c_data  <= {mem_q, sdr_data[15:0]};
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  // state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      to_cnt      <= '0;
      timeout_cnt <= '0;
      mem_addr    <= '0;
      mem_req     <= 1'b0;
      sdr_data    <= '0;
      sdr_rdy     <= 1'b0;
    end else begin
      state       <= state_n;
      to_cnt      <= to_cnt_n;
      timeout_cnt <= tcnt_n;
      mem_addr    <= mem_addr_n;
      mem_req     <= mem_req_n;
      sdr_data    <= sdr_data_n;
      sdr_rdy     <= sdr_rdy_n;
    end
  end

  // next state, beat assembly, timeout and pending pop
  always_comb begin
    state_n    = state;
    mem_addr_n = mem_addr;
    mem_req_n  = mem_req;
    sdr_data_n = sdr_data;
    sdr_rdy_n  = 1'b0;
    tcnt_n     = timeout_cnt;
    pop        = 1'b0;
    to_cnt_n   = to_cnt;
    if (to_cnt != '1) to_cnt_n = to_cnt + 1'b1;
    if (expire) begin
      mem_req_n  = 1'b0;
      sdr_data_n = ERR_DATA;
      sdr_rdy_n  = 1'b1;
      state_n    = IDLE;
      if (timeout_cnt != 8'hFF) tcnt_n = timeout_cnt + 8'd1;
    end else begin
      unique case (state)
        IDLE: begin
          to_cnt_n = '0;
          if (req_v) begin
            pop = pend_valid;
            if (hit) begin
              sdr_data_n = hit_data;
              sdr_rdy_n  = 1'b1;
            end else begin
              mem_addr_n = req_base;
              mem_req_n  = 1'b1;
              state_n    = CMD;
            end
          end
        end
        CMD: begin
          if (mem_ack) begin
            mem_req_n = 1'b0;
            state_n   = BEAT0;
            if (mem_dv) begin
              sdr_data_n[15:0] = mem_q;
              state_n          = BEAT1;
            end
          end
        end
        BEAT0: begin
          if (mem_dv) begin
            sdr_data_n[15:0] = mem_q;
            state_n          = BEAT1;
          end
        end
        BEAT1: begin
          if (mem_dv) begin
            sdr_data_n[31:16] = mem_q;
            sdr_rdy_n         = 1'b1;
            state_n           = IDLE;
            if (pend_valid) begin
              pop        = 1'b1;
              mem_addr_n = pend_addr & ADDR_MASK;
              mem_req_n  = 1'b1;
              to_cnt_n   = '0;
              state_n    = CMD;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gfx_sdram_responder.sv
// tb_gfx_sdram_responder: scoreboard bench with a scripted
// SDRAM controller model and a decoupled sdr_rdy monitor.
module tb_gfx_sdram_responder;

  typedef struct {
    logic [31:0] data;
    int          due;
  } sb_t;

  typedef struct {
    logic [24:0] addr;
    int          ack_dly;
    int          g0;
    int          g1;
    int          start_due;
    logic [15:0] lo;
    logic [15:0] hi;
  } ctl_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [24:0] sdr_addr;
  logic        sdr_req;
  logic [31:0] sdr_data;
  logic        sdr_rdy;
  logic [24:0] mem_addr;
  logic        mem_req;
  logic        mem_ack, mem_dv;
  logic [15:0] mem_q;
  logic        busy, overflow;
  logic [7:0]  timeout_cnt;

  logic        c_ack = 1'b0, c_dv = 1'b0;
  logic [15:0] c_q = '0;
  logic        m_ack = 1'b0, m_dv = 1'b0;
  logic [15:0] m_q = '0;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   ctl_auto = 1'b1;
  bit   prev_rdy = 1'b0;
  sb_t  sb_q[$];
  ctl_t ctl_q[$];

  assign mem_ack = c_ack | m_ack;
  assign mem_dv  = c_dv | m_dv;
  assign mem_q   = c_q | m_q;

  gfx_sdram_responder #(.TIMEOUT_CYCLES(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .sdr_addr    (sdr_addr),
    .sdr_req     (sdr_req),
    .sdr_data    (sdr_data),
    .sdr_rdy     (sdr_rdy),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_dv      (mem_dv),
    .mem_q       (mem_q),
    .busy        (busy),
    .overflow    (overflow),
    .timeout_cnt (timeout_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // monitor: pop expected word on every sdr_rdy pulse
  always @(negedge clk) begin : mon
    sb_t e;
    if (sdr_rdy) begin
      chk("rdy_back2back", 32'(prev_rdy), 32'd0);
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rdy: got data %h want none",
                 sdr_data);
      end else begin
        e = sb_q.pop_front();
        chk("rdy_data", sdr_data, e.data);
        if (e.due >= 0) chk("rdy_cycle", 32'(cyc), 32'(e.due));
      end
    end
    prev_rdy = sdr_rdy;
  end

  // scripted controller: ack and two beats per command
  initial begin : ctl
    ctl_t t;
    @(negedge clk);
    forever begin
      if (ctl_auto && mem_req && !reset) begin
        if (ctl_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_mem_req: addr %h want none",
                   mem_addr);
          @(negedge clk);
        end else begin
          t = ctl_q.pop_front();
          chk("mem_addr", 32'(mem_addr), 32'(t.addr));
          if (t.start_due >= 0)
            chk("mem_req_cycle", 32'(cyc), 32'(t.start_due));
          repeat (t.ack_dly) @(negedge clk);
          c_ack = 1'b1;
          if (t.g0 == 0) begin
            c_dv = 1'b1;
            c_q  = t.lo;
          end
          @(negedge clk);
          c_ack = 1'b0;
          c_dv  = 1'b0;
          c_q   = '0;
          if (t.g0 != 0) begin
            repeat (t.g0 - 1) @(negedge clk);
            c_dv = 1'b1;
            c_q  = t.lo;
            @(negedge clk);
            c_dv = 1'b0;
            c_q  = '0;
          end
          repeat (t.g1 - 1) @(negedge clk);
          c_dv = 1'b1;
          c_q  = t.hi;
          @(negedge clk);
          c_dv = 1'b0;
          c_q  = '0;
        end
      end else begin
        @(negedge clk);
      end
    end
  end

  task automatic issue(input logic [24:0] a);
    sdr_addr = a;
    sdr_req  = 1'b1;
    @(negedge clk);
    sdr_req  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb_q.size() != 0 || ctl_q.size() != 0)
           && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL wait_idle: busy=%0b sb=%0d want drained",
               busy, sb_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic read(input logic [24:0] a,
                      input logic [31:0] d);
    int r = cyc;
    ctl_q.push_back('{a & 25'h1FF_FFFC, 0, 1, 1, r + 1,
                      d[15:0], d[31:16]});
    sb_q.push_back('{d, r + 4});
    issue(a);
    wait_idle();
  endtask

  initial begin : main
    int r;
    reset    = 1'b1;
    sdr_req  = 1'b0;
    sdr_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_sdr_data", sdr_data, 32'd0);
    chk("rst_sdr_rdy", 32'(sdr_rdy), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // single read, zero-wait ack
    r = cyc;
    ctl_q.push_back('{25'h0100004, 0, 1, 1, r + 1,
                      16'h1234, 16'hABCD});
    sb_q.push_back('{32'hABCD_1234, r + 4});
    issue(25'h0100006);
    chk("busy_inflight", 32'(busy), 32'd1);
    wait_idle();

    // ack with beat 0, beat 1 three cycles later
    r = cyc;
    ctl_q.push_back('{25'h0000010, 2, 0, 3, r + 1,
                      16'hC3C3, 16'h5A5A});
    sb_q.push_back('{32'h5A5A_C3C3, r + 7});
    issue(25'h0000013);
    wait_idle();

    // A, B pending, C dropped
    r = cyc;
    ctl_q.push_back('{25'h0000100, 3, 2, 2, r + 1,
                      16'h0055, 16'h00AA});
    ctl_q.push_back('{25'h0000200, 0, 1, 1, r + 9,
                      16'hF00D, 16'hBEEF});
    sb_q.push_back('{32'h00AA_0055, r + 9});
    sb_q.push_back('{32'hBEEF_F00D, r + 12});
    issue(25'h0000100);
    @(negedge clk);
    issue(25'h0000200);
    @(negedge clk);
    issue(25'h0000300);
    chk("overflow_set", 32'(overflow), 32'd1);
    wait_idle();
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // timeout with silent controller
    ctl_auto = 1'b0;
    r = cyc;
    sb_q.push_back('{32'hFFFF_FFFF, r + 11});
    issue(25'h0000400);
    wait_idle();
    chk("to_mem_req", 32'(mem_req), 32'd0);
    chk("to_count", 32'(timeout_cnt), 32'd1);
    m_dv = 1'b1;
    m_q  = 16'hDEAD;
    @(negedge clk);
    m_dv = 1'b0;
    m_q  = '0;
    repeat (3) @(negedge clk);
    chk("to_stray_busy", 32'(busy), 32'd0);
    ctl_auto = 1'b1;
    read(25'h0000404, 32'h2222_1111);

    // reset during BEAT1
    ctl_auto = 1'b0;
    issue(25'h0000800);
    m_ack = 1'b1;
    m_dv  = 1'b1;
    m_q   = 16'h5555;
    @(negedge clk);
    m_ack = 1'b0;
    m_dv  = 1'b0;
    m_q   = '0;
    chk("beat1_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_rdy", 32'(sdr_rdy), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_data", sdr_data, 32'd0);
    chk("rst_mid_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_dv  = 1'b1;
    m_q   = 16'h6666;
    @(negedge clk);
    m_dv  = 1'b0;
    m_q   = '0;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    ctl_auto = 1'b1;
    read(25'h0000808, 32'h4444_3333);

`ifdef GFX_SDRAM_LINE_CACHE_EN
    // cache hit, then miss after a timed-out read
    read(25'h0000200, 32'h7777_8888);
    r = cyc;
    sb_q.push_back('{32'h7777_8888, r + 1});
    issue(25'h0000202);
    chk("hit_no_req", 32'(mem_req), 32'd0);
    wait_idle();
    read(25'h0000300, 32'h0303_3030);
    ctl_auto = 1'b0;
    r = cyc;
    sb_q.push_back('{32'hFFFF_FFFF, r + 11});
    issue(25'h0000200);
    chk("miss_req", 32'(mem_req), 32'd1);
    wait_idle();
    ctl_auto = 1'b1;
    read(25'h0000200, 32'h9999_AAAA);
`endif

    repeat (3) @(negedge clk);
    chk("end_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
